// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal-entry blocks: FSM encoding, sizes and
// the largest legal BCD digit.
package bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MAX_DIGITS = 5;
  localparam int ACC_W      = 17;
  localparam int CNT_W      = $clog2(MAX_DIGITS);

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle of the BCD-to-binary converter.
// The master issues requests and the slave converts them.
interface bcd_to_binary_if #(
  parameter int NDIGITS = 5,
  parameter int BIN_W   = 16
);

  logic                   start;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic                   busy;
  logic                   done;
  logic [BIN_W-1:0]       binary_out;
  logic                   err;
  logic                   ovf;

  modport master (
    output start, bcd_in,
    input  busy, done, binary_out, err, ovf
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, binary_out, err, ovf
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// Combinational decimal accumulate step: acc*10 + digit using shift-add,
// plus a flag telling whether the digit is a legal BCD value.
module bcd_digit_mac
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             digit_ok_o
);

  // acc*10 as (acc<<3)+(acc<<1); overflow past ACC_W only happens with illegal digits
  always_comb begin
    acc_o      = (acc_i << 3'd3) + (acc_i << 3'd1) + {{(ACC_W-4){1'b0}}, digit_i};
    digit_ok_o = (digit_i <= BCD_DIGIT_MAX);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle BCD-to-binary converter: one digit per clock, most significant
// first, with sticky invalid-digit and overflow reporting at done.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 5,
  parameter int BIN_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  bcd_to_binary_if.slave bus
);

  localparam int               SR_W     = 4 * NDIGITS;
  localparam logic [ACC_W-1:0] BIN_MAX  = ACC_W'((32'd1 << BIN_W) - 32'd1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NDIGITS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    shreg_q, shreg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               inv_q, inv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   mac_acc_s;
  logic               mac_ok_s;
  logic               last_s;
  logic               fin_inv_s;

  bcd_digit_mac u_mac (
    .acc_i      (acc_q),
    .digit_i    (shreg_q[SR_W-1 -: 4]),
    .acc_o      (mac_acc_s),
    .digit_ok_o (mac_ok_s)
  );

  assign last_s    = (cnt_q == {CNT_W{1'b0}});
  assign fin_inv_s = inv_q | ~mac_ok_s;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      shreg_q <= {SR_W{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= {BIN_W{1'b0}};
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    inv_d   = inv_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.bcd_in;
          acc_d   = {ACC_W{1'b0}};
          inv_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        acc_d   = mac_acc_s;
        inv_d   = fin_inv_s;
        shreg_d = shreg_q << 3'd4;
        if (last_s) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          // An invalid digit wins over overflow: the arithmetic was meaningless
          if (fin_inv_s) begin
            bin_d = {BIN_W{1'b0}};
            err_d = 1'b1;
            ovf_d = 1'b0;
          end else if (mac_acc_s > BIN_MAX) begin
            bin_d = {BIN_W{1'b1}};
            err_d = 1'b0;
            ovf_d = 1'b1;
          end else begin
            bin_d = mac_acc_s[BIN_W-1:0];
            err_d = 1'b0;
            ovf_d = 1'b0;
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(32'd1);
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.binary_out = bin_q;
  assign bus.err        = err_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Multi-cycle BCD-to-binary converter: accepts a packed NDIGITS-digit BCD value on a start pulse and produces its unsigned binary equivalent NDIGITS cycles later. It evaluates one digit per clock, most-significant first, as acc = acc*10 + digit. It sits on the input side of the display/keypad path, turning operator-entered decimal digits back into binary. Sticky flags report invalid digits and results that exceed the output width.

## Interface
- NDIGITS, 5, number of BCD digits; legal range 1..5.
- BIN_W, 16, output width in bits; legal range 1..16.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- bcd_in  in  4*NDIGITS  packed BCD; digit k occupies bits [4k+3:4k]; digit NDIGITS-1 is most significant.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- binary_out  out  BIN_W  result; held until the next done.
- err  out  1  last result had a digit greater than 9; updated with done.
- ovf  out  1  last result exceeded 2^BIN_W-1; updated with done.

## Operation
- States: IDLE and RUN.
- **IDLE:**
  - On start=1, capture bcd_in into a shift register, clear the 17-bit accumulator and the invalid flag, and load digit count = NDIGITS-1.
  - Go to RUN; busy=1.
- **RUN, each cycle:**
  - Take the top digit d of the shift register.
  - acc <= (acc<<3) + (acc<<1) + d.
  - If d > 9: set the invalid flag, and use d for the arithmetic anyway (the result is discarded).
  - Shift the register left by 4 and decrement the count.
- **RUN, when count = 0 (last digit):**
  - Compute the final accumulator value.
  - Register the outputs, pulse done, drop busy, return to IDLE.
- **Output rules at done:**
  - If invalid: binary_out=0, err=1, ovf=0.
  - Else if final acc > 2^BIN_W-1: binary_out = all ones (saturate), ovf=1, err=0.
  - Else: binary_out = acc[BIN_W-1:0], err=0, ovf=0.
- Accumulator is 17 bits: 99999 < 2^17, so no internal wrap for any legal NDIGITS.
- start while busy is ignored; no queueing.
- bcd_in is sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset values: busy=0, done=0, binary_out=0, err=0, ovf=0, state IDLE, accumulator 0.
- Start accepted at edge E0:
  - busy=1 from E0 until edge E0+NDIGITS.
  - done=1 for exactly one cycle following edge E0+NDIGITS.
  - binary_out, err and ovf change only at that same edge.
- Latency is NDIGITS cycles from the accepting edge to done.
- Back-to-back: start high during the done cycle is accepted at the next edge, giving one conversion per NDIGITS+1 cycles.
- Reset mid-conversion aborts immediately:
  - All outputs return to their reset values.
  - No done is issued for the aborted request.
- done and busy are never high in the same cycle.

## Structure
- Shared package bcd_pkg holds:
  - state encoding (IDLE/RUN);
  - MAX_DIGITS=5;
  - ACC_W=17;
  - BCD_DIGIT_MAX=4'd9.
- Optional sub-module bcd_digit_mac: combinational acc*10 + d using shift-add, plus a digit-valid compare. It is reusable by other decimal-entry blocks.
- Top level contains the FSM, digit counter, shift register and output registers.

## Test plan
- Reset, then start with bcd_in=20'h00234 -> busy for 5 cycles; done one cycle later; binary_out=234, err=0, ovf=0.
- bcd_in=20'h65535 -> binary_out=65535 (16'hFFFF), ovf=0; then bcd_in=20'h65536 -> binary_out=16'hFFFF, ovf=1.
- bcd_in=20'h1A345 -> err=1, binary_out=0, ovf=0; next conversion of 20'h00009 -> binary_out=9, err cleared.
- Start pulsed at cycles 1 and 3 with different bcd_in -> only the first converted; exactly one done, at 5 cycles after acceptance.
- Reset asserted 2 cycles into a conversion of 20'h99999 -> outputs zero at once, no done; a new start of 20'h00042 yields 42.
- Start held high continuously with bcd_in=20'h00100 -> done every 6 cycles, binary_out=100 each time.
